hdmi_box_scaler: RTL and testbench

- Sits between hdmi_stream and the LED framebuffer write port, in the hdmi_clk domain.
- Crops a window of OUT_WIDTH*SCALE by OUT_HEIGHT*SCALE HDMI pixels and box-averages each SCALE x SCALE block into one LED pixel.
- Emits one framebuffer write per output pixel.
- Lets the 104x32 train panels show a downscaled desktop region instead of a 1:1 crop.

---
 rtl/hdmi_pkg.sv | 14 +
 rtl/hdmi_box_scaler_if.sv | 41 ++++
 rtl/box_col_store.sv | 30 +++
 rtl/hdmi_box_scaler.sv | 198 +++++++++++++++++++
 tb/tb_hdmi_box_scaler.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hdmi_pkg.sv
// Shared HDMI definitions used by hdmi_stream, hdmi_box_scaler and the LED framebuffer.
//   HDMI_COORD_W : width of the HDMI x/y pixel coordinates
//   rgb888_t     : one 24-bit pixel, 8 bits per channel
package hdmi_pkg;

    localparam int unsigned HDMI_COORD_W = 12;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

endpackage

// File: rtl/hdmi_box_scaler_if.sv
// Pixel-in / framebuffer-write-out bundle of hdmi_box_scaler.
//   xaddr, yaddr, rgb_valid, vsync, r, g, b : incoming HDMI pixel stream
//   wr_en, wr_x, wr_y, wr_r, wr_g, wr_b     : one framebuffer write per output pixel
//   frame_done                              : pulse after the last output pixel of a frame
// master: the side that sources pixels and sinks writes; slave: the scaler.
interface hdmi_box_scaler_if #(
    parameter int unsigned OUT_WIDTH  = 128,
    parameter int unsigned OUT_HEIGHT = 32
);
    import hdmi_pkg::*;

    localparam int unsigned XW = $clog2(OUT_WIDTH);
    localparam int unsigned YW = $clog2(OUT_HEIGHT);

    logic [HDMI_COORD_W-1:0] xaddr;
    logic [HDMI_COORD_W-1:0] yaddr;
    logic                    rgb_valid;
    logic                    vsync;
    logic [7:0]              r;
    logic [7:0]              g;
    logic [7:0]              b;

    logic                    wr_en;
    logic [XW-1:0]           wr_x;
    logic [YW-1:0]           wr_y;
    logic [7:0]              wr_r;
    logic [7:0]              wr_g;
    logic [7:0]              wr_b;
    logic                    frame_done;

    modport master (
        output xaddr, yaddr, rgb_valid, vsync, r, g, b,
        input  wr_en, wr_x, wr_y, wr_r, wr_g, wr_b, frame_done
    );

    modport slave (
        input  xaddr, yaddr, rgb_valid, vsync, r, g, b,
        output wr_en, wr_x, wr_y, wr_r, wr_g, wr_b, frame_done
    );

endinterface

// File: rtl/box_col_store.sv
// Simple dual-port synchronous RAM (one write port, one registered read port).
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata is valid the cycle after re and holds until the next read
// No reset on the array or read register so it maps onto block RAM.
module box_col_store #(
    parameter int unsigned WIDTH = 30,
    parameter int unsigned DEPTH = 128
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/hdmi_box_scaler.sv
// Crops an (OUT_WIDTH<<S) x (OUT_HEIGHT<<S) window of the HDMI stream starting at
// (MIN_X, MIN_Y) and box-averages every (1<<S) x (1<<S) block into one LED pixel.
//   clk, reset : HDMI pixel clock, asynchronous active-high reset
//   bus        : pixel stream in, framebuffer writes and frame_done out
// Horizontal sums live in h_acc; partial vertical sums per output column live in the
// column store, which is read on the first pixel of a block and written on its last.
module hdmi_box_scaler
    import hdmi_pkg::*;
#(
    parameter int unsigned MIN_X       = 50,
    parameter int unsigned MIN_Y       = 110,
    parameter int unsigned OUT_WIDTH   = 128,
    parameter int unsigned OUT_HEIGHT  = 32,
    parameter int unsigned SCALE_SHIFT = 1
) (
    input  logic             clk,
    input  logic             reset,
    hdmi_box_scaler_if.slave bus
);

    localparam int unsigned S     = SCALE_SHIFT;
    localparam int unsigned HW    = 8 + S;
    localparam int unsigned CW    = 8 + 2 * S;
    localparam int unsigned XW    = $clog2(OUT_WIDTH);
    localparam int unsigned YW    = $clog2(OUT_HEIGHT);
    localparam int unsigned WIN_W = OUT_WIDTH << S;
    localparam int unsigned WIN_H = OUT_HEIGHT << S;
    localparam logic [S-1:0] SUB_LAST = '1;

    rgb888_t                 pix;
    logic [2:0][7:0]         pix_ch;
    logic [HDMI_COORD_W-1:0] dx;
    logic [HDMI_COORD_W-1:0] dy;
    logic                    in_win;
    logic [XW-1:0]           ox;
    logic [YW-1:0]           oy;
    logic [S-1:0]            sx;
    logic [S-1:0]            sy;

    logic [2:0][HW-1:0] h_acc_q, h_acc_d;
    logic               h_valid_q, h_valid_d;
    logic [XW-1:0]      h_ox_q, h_ox_d;
    logic               armed_q, armed_d;
    logic               vsync_q;
    logic               vs_fall;
    logic               complete;

    logic [2:0][HW-1:0] sum;
    logic [2:0][CW-1:0] total;
    logic [2:0][CW-1:0] col_rd;
    logic [2:0][CW-1:0] col_wd;
    logic               col_we;
    logic               col_re;

    logic               wr_en_q, wr_en_d;
    logic [XW-1:0]      wr_x_q, wr_x_d;
    logic [YW-1:0]      wr_y_q, wr_y_d;
    logic [2:0][7:0]    wr_c_q, wr_c_d;
    logic               frame_done_q, frame_done_d;

    assign pix    = '{r: bus.r, g: bus.g, b: bus.b};
    assign pix_ch = {pix.r, pix.g, pix.b};

    // Unsigned wrap makes pixels left of / above the window fail the range test.
    assign dx     = bus.xaddr - HDMI_COORD_W'(MIN_X);
    assign dy     = bus.yaddr - HDMI_COORD_W'(MIN_Y);
    assign in_win = bus.rgb_valid && (32'(dx) < WIN_W) && (32'(dy) < WIN_H);
    assign ox     = dx[S +: XW];
    assign oy     = dy[S +: YW];
    assign sx     = dx[S-1:0];
    assign sy     = dy[S-1:0];

    assign vs_fall = vsync_q && !bus.vsync;

    box_col_store #(
        .WIDTH (3 * CW),
        .DEPTH (OUT_WIDTH)
    ) u_col_store (
        .clk   (clk),
        .we    (col_we),
        .waddr (ox),
        .wdata (col_wd),
        .re    (col_re),
        .raddr (ox),
        .rdata (col_rd)
    );

    always_comb begin
        h_acc_d      = h_acc_q;
        h_valid_d    = h_valid_q;
        h_ox_d       = h_ox_q;
        armed_d      = armed_q;
        col_we       = 1'b0;
        col_re       = 1'b0;
        col_wd       = '0;
        complete     = 1'b0;
        wr_en_d      = 1'b0;
        wr_x_d       = wr_x_q;
        wr_y_d       = wr_y_q;
        wr_c_d       = wr_c_q;
        frame_done_d = wr_en_q && (wr_x_q == '1) && (wr_y_q == '1);

        for (int c = 0; c < 3; c++) begin
            sum[c]   = h_acc_q[c] + HW'(pix_ch[c]);
            total[c] = col_rd[c] + CW'(sum[c]);
        end

        if (in_win) begin
            if (dy == '0) begin
                armed_d = 1'b1;
            end
            if (sx == '0) begin
                // First pixel of a block: restart the sum and fetch the column partial.
                for (int c = 0; c < 3; c++) begin
                    h_acc_d[c] = HW'(pix_ch[c]);
                end
                h_ox_d    = ox;
                h_valid_d = 1'b1;
                col_re    = 1'b1;
            end else if (h_valid_q && (ox == h_ox_q)) begin
                if (sx == SUB_LAST) begin
                    complete  = 1'b1;
                    h_valid_d = 1'b0;
                end else begin
                    for (int c = 0; c < 3; c++) begin
                        h_acc_d[c] = sum[c];
                    end
                end
            end else begin
                // Column changed mid-block: drop the partial block.
                h_valid_d = 1'b0;
            end
        end

        if (complete) begin
            if (sy == '0) begin
                col_we = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    col_wd[c] = CW'(sum[c]);
                end
            end else if (sy != SUB_LAST) begin
                col_we = 1'b1;
                col_wd = total;
            end else begin
                wr_en_d = armed_q;
                if (armed_q) begin
                    wr_x_d = ox;
                    wr_y_d = oy;
                    for (int c = 0; c < 3; c++) begin
                        wr_c_d[c] = 8'(total[c] >> (2 * S));
                    end
                end
            end
        end

        // A completing write in the same cycle still goes out; only state is cleared.
        if (vs_fall) begin
            h_acc_d   = '0;
            h_valid_d = 1'b0;
            armed_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_acc_q      <= '0;
            h_valid_q    <= 1'b0;
            h_ox_q       <= '0;
            armed_q      <= 1'b0;
            vsync_q      <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_x_q       <= '0;
            wr_y_q       <= '0;
            wr_c_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            h_acc_q      <= h_acc_d;
            h_valid_q    <= h_valid_d;
            h_ox_q       <= h_ox_d;
            armed_q      <= armed_d;
            vsync_q      <= bus.vsync;
            wr_en_q      <= wr_en_d;
            wr_x_q       <= wr_x_d;
            wr_y_q       <= wr_y_d;
            wr_c_q       <= wr_c_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_x       = wr_x_q;
    assign bus.wr_y       = wr_y_q;
    assign bus.wr_r       = wr_c_q[2];
    assign bus.wr_g       = wr_c_q[1];
    assign bus.wr_b       = wr_c_q[0];
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_hdmi_box_scaler.sv
// Scoreboard bench for hdmi_box_scaler. Three instances share one pixel stream, gated by sel:
//   dut0: window at (0,0),    4x2 out, S=1
//   dut1: window at (50,110), 4x2 out, S=1
//   dut2: window at (0,0),    4x2 out, S=2
module tb_hdmi_box_scaler;
    import hdmi_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] xaddr, yaddr;
    logic        valid, vsync;
    logic [7:0]  r, g, b;
    int          sel;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hdmi_box_scaler_if #(.OUT_WIDTH(4), .OUT_HEIGHT(2)) bus0 ();
    hdmi_box_scaler_if #(.OUT_WIDTH(4), .OUT_HEIGHT(2)) bus1 ();
    hdmi_box_scaler_if #(.OUT_WIDTH(4), .OUT_HEIGHT(2)) bus2 ();

    assign bus0.xaddr = xaddr;  assign bus1.xaddr = xaddr;  assign bus2.xaddr = xaddr;
    assign bus0.yaddr = yaddr;  assign bus1.yaddr = yaddr;  assign bus2.yaddr = yaddr;
    assign bus0.vsync = vsync;  assign bus1.vsync = vsync;  assign bus2.vsync = vsync;
    assign bus0.r = r;  assign bus1.r = r;  assign bus2.r = r;
    assign bus0.g = g;  assign bus1.g = g;  assign bus2.g = g;
    assign bus0.b = b;  assign bus1.b = b;  assign bus2.b = b;
    assign bus0.rgb_valid = valid && (sel == 0);
    assign bus1.rgb_valid = valid && (sel == 1);
    assign bus2.rgb_valid = valid && (sel == 2);

    hdmi_box_scaler #(.MIN_X(0), .MIN_Y(0), .OUT_WIDTH(4), .OUT_HEIGHT(2), .SCALE_SHIFT(1))
        u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
    hdmi_box_scaler #(.MIN_X(50), .MIN_Y(110), .OUT_WIDTH(4), .OUT_HEIGHT(2), .SCALE_SHIFT(1))
        u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
    hdmi_box_scaler #(.MIN_X(0), .MIN_Y(0), .OUT_WIDTH(4), .OUT_HEIGHT(2), .SCALE_SHIFT(2))
        u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

    typedef struct {
        int         x;
        int         y;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         cyc;
    } exp_t;

    exp_t exp_q[3][$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   fd_exp[3];
    int   min_x[3] = '{0, 50, 0};
    int   min_y[3] = '{0, 110, 0};
    int   sc[3]    = '{2, 2, 4};

    task automatic mon(input int k, input logic en, input logic [1:0] x, input logic y,
                       input logic [7:0] vr, input logic [7:0] vg, input logic [7:0] vb,
                       input logic fd);
        exp_t e;
        bit   last;
        last = 1'b0;
        if (fd || fd_exp[k]) begin
            n_cmp++;
            if (fd !== fd_exp[k]) begin
                n_bad++;
                $display("FAIL frame_done dut%0d cycle %0d: got %0b want %0b", k, cyc, fd,
                         fd_exp[k]);
            end
        end
        if (en) begin
            n_cmp++;
            if (exp_q[k].size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write dut%0d cycle %0d: got x=%0d y=%0d rgb=%h%h%h want none",
                         k, cyc, x, y, vr, vg, vb);
            end else begin
                e = exp_q[k].pop_front();
                last = (e.x == 3) && (e.y == 1);
                if ({x, y, vr, vg, vb} !== {2'(e.x), 1'(e.y), e.r, e.g, e.b} || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL write dut%0d: got x=%0d y=%0d rgb=%h%h%h cyc=%0d want x=%0d y=%0d rgb=%h%h%h cyc=%0d",
                             k, x, y, vr, vg, vb, cyc, e.x, e.y, e.r, e.g, e.b, e.cyc);
                end
            end
        end
        fd_exp[k] = en && last;
    endtask

    always @(negedge clk) mon(0, bus0.wr_en, bus0.wr_x, bus0.wr_y, bus0.wr_r, bus0.wr_g,
                              bus0.wr_b, bus0.frame_done);
    always @(negedge clk) mon(1, bus1.wr_en, bus1.wr_x, bus1.wr_y, bus1.wr_r, bus1.wr_g,
                              bus1.wr_b, bus1.frame_done);
    always @(negedge clk) mon(2, bus2.wr_en, bus2.wr_x, bus2.wr_y, bus2.wr_r, bus2.wr_g,
                              bus2.wr_b, bus2.frame_done);

    function automatic logic [7:0] pv(input int mode, input int ch, input int x, input int y);
        int v;
        case (mode)
            0:       v = 8'h80;
            1:       v = (ch == 0) ? x + y : (ch == 1) ? (x + y) * 8 : x ^ y;
            2:       v = (x < 50 || y < 110) ? 8'hFF : 8'h10;
            default: v = (ch == 0) ? x * 37 + y * 11 : (ch == 1) ? x * 5 + y * 71
                                                     : 255 - ((x * 37 + y * 11) & 255);
        endcase
        return 8'(v);
    endfunction

    task automatic push(input int k, input int x, input int y, input logic [7:0] er,
                        input logic [7:0] eg, input logic [7:0] eb);
        exp_t e;
        e.x = x; e.y = y; e.r = er; e.g = eg; e.b = eb;
        e.cyc = cyc + 1;
        exp_q[k].push_back(e);
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic vsync_pulse();
        valid = 1'b0;
        vsync = 1'b0;
        @(posedge clk);
        #1;
        vsync = 1'b1;
        idle(2);
    endtask

    task automatic drive_px(input int k, input int x, input int y, input logic [7:0] pr,
                            input logic [7:0] pg, input logic [7:0] pb, input bit do_rst);
        sel   = k;
        valid = 1'b1;
        xaddr = 12'(x);
        yaddr = 12'(y);
        r = pr; g = pg; b = pb;
        if (do_rst) reset = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        if (do_rst) begin
            @(posedge clk);
            #1;
            reset = 1'b0;
        end
    endtask

    // Raster over [xs, xs+w) x [ys, ys+h); expectations come from a block-mean model.
    task automatic drive_frame(input int k, input int xs, input int ys, input int w,
                               input int h, input int mode, input int rst_y);
        bit armed, dead, do_rst;
        int dx, dy, s;
        int acc[3];
        vsync_pulse();
        armed = 0;
        dead  = 0;
        s     = sc[k];
        for (int y = ys; y < ys + h; y++) begin
            for (int x = xs; x < xs + w; x++) begin
                do_rst = (y == rst_y) && (x == xs);
                if (do_rst) dead = 1;
                dx = x - min_x[k];
                dy = y - min_y[k];
                if (!dead && dx >= 0 && dx < 4 * s && dy >= 0 && dy < 2 * s) begin
                    if (dy == 0) armed = 1;
                    if (armed && (dx % s) == s - 1 && (dy % s) == s - 1) begin
                        for (int c = 0; c < 3; c++) begin
                            acc[c] = 0;
                            for (int i = 0; i < s; i++)
                                for (int j = 0; j < s; j++)
                                    acc[c] += int'(pv(mode, c, x - i, y - j));
                        end
                        push(k, dx / s, dy / s, 8'(acc[0] / (s * s)), 8'(acc[1] / (s * s)),
                             8'(acc[2] / (s * s)));
                    end
                end
                drive_px(k, x, y, pv(mode, 0, x, y), pv(mode, 1, x, y), pv(mode, 2, x, y),
                         do_rst);
            end
            idle(2);
        end
        idle(4);
    endtask

    task automatic check_rst(input int k, input logic [28:0] v);
        n_cmp++;
        if (v !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs dut%0d: got %h want 0", k, v);
        end
    endtask

    initial begin
        reset = 1'b1;
        vsync = 1'b1;
        valid = 1'b0;
        sel   = 0;
        xaddr = '0; yaddr = '0;
        r = '0; g = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_rst(0, {bus0.wr_en, bus0.wr_x, bus0.wr_y, bus0.wr_r, bus0.wr_g, bus0.wr_b,
                      bus0.frame_done});
        check_rst(1, {bus1.wr_en, bus1.wr_x, bus1.wr_y, bus1.wr_r, bus1.wr_g, bus1.wr_b,
                      bus1.frame_done});
        check_rst(2, {bus2.wr_en, bus2.wr_x, bus2.wr_y, bus2.wr_r, bus2.wr_g, bus2.wr_b,
                      bus2.frame_done});
        reset = 1'b0;
        idle(2);

        // Constant fill: 8 writes of 0x80 in raster order, then frame_done.
        drive_frame(0, 0, 0, 8, 4, 0, -1);

        // Averaging: (0xFF + 0x00 + 0x01 + 0x02) >> 2 = 0x40, one cycle after 4th pixel.
        vsync_pulse();
        drive_px(0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        drive_px(0, 1, 0, 8'h00, 8'h00, 8'h00, 1'b0);
        idle(2);
        drive_px(0, 0, 1, 8'h01, 8'h01, 8'h01, 1'b0);
        push(0, 0, 0, 8'h40, 8'h40, 8'h40);
        drive_px(0, 1, 1, 8'h02, 8'h02, 8'h02, 1'b0);
        idle(4);

        // Same block with a 3-cycle rgb_valid gap before the last pixel.
        vsync_pulse();
        drive_px(0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        drive_px(0, 1, 0, 8'h00, 8'h00, 8'h00, 1'b0);
        idle(2);
        drive_px(0, 0, 1, 8'h01, 8'h01, 8'h01, 1'b0);
        idle(3);
        push(0, 0, 0, 8'h40, 8'h40, 8'h40);
        drive_px(0, 1, 1, 8'h02, 8'h02, 8'h02, 1'b0);
        idle(4);

        // Window crop: border pixels at x=49 / y=109 are 0xFF, inside is 0x10.
        drive_frame(1, 49, 109, 9, 5, 2, -1);

        // Mid-frame reset during output row 1, then a clean frame.
        drive_frame(0, 0, 0, 8, 4, 3, 2);
        drive_frame(0, 0, 0, 8, 4, 3, -1);

        // S=2 ramp: each output is the floor of its 4x4 block mean.
        drive_frame(2, 0, 0, 16, 8, 1, -1);

        // S=2 block whose last line jumps into the next column: no write expected.
        vsync_pulse();
        for (int y = 0; y < 4; y++) begin
            for (int i = 0; i < 4; i++) begin
                int x;
                x = (y == 3 && i == 2) ? 6 : i;
                drive_px(2, x, y, pv(1, 0, x, y), pv(1, 1, x, y), pv(1, 2, x, y), 1'b0);
            end
            idle(2);
        end
        idle(10);

        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (exp_q[k].size() != 0) begin
                n_bad++;
                $display("FAIL missing_writes dut%0d: got %0d outstanding want 0", k,
                         exp_q[k].size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
